// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains fifo_async on the read clock into a 2-entry valid/ready buffer.
// Provides flush/drain, a handshake counter and sticky underflow capture.
module fifo_rd_stream #(
    parameter int FIFODEPTH    = 16,
    parameter int FIFOWIDTH    = 72,
    parameter int FIFOPTRWIDTH = 4,
    parameter int CNTWIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FIFOPTRWIDTH:0]   fifo_numfilled,
    input  logic [FIFOWIDTH-1:0]    fifo_rdata,
    input  logic                    fifo_underflow,
    output logic                    fifo_rstb,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [FIFOWIDTH-1:0]    out_data,
    input  logic                    out_ready,
    output logic [CNTWIDTH-1:0]     word_count,
    output logic                    err_underflow,
    output logic                    busy
);
    typedef enum logic {RUN, DRAIN} state_t;

    if (FIFODEPTH != (1 << FIFOPTRWIDTH)) begin : g_bad_depth
        $error("FIFODEPTH must equal 2**FIFOPTRWIDTH");
    end

    state_t               state;
    logic [1:0]           count;
    logic [FIFOWIDTH-1:0] b0, b1;
    logic                 has_data, push, pop;

    assign has_data  = fifo_numfilled != '0;
    assign push      = fifo_rstb && state == RUN;
    assign pop       = out_valid && out_ready;
    assign out_valid = count != 2'd0;
    assign out_data  = b0;
    assign busy      = state == DRAIN;

    // Strobe depends only on registers and FIFO-side inputs, never on out_ready.
    always_comb fifo_rstb = rst ? 1'b0 : state == DRAIN ? has_data : has_data && count != 2'd2 && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            count         <= 2'd0;
            b0            <= '0;
            b1            <= '0;
            word_count    <= '0;
            err_underflow <= 1'b0;
        end else begin
            err_underflow <= err_underflow | fifo_underflow;
            if (flush) begin
                state      <= DRAIN;
                count      <= 2'd0;
                word_count <= '0;
            end else if (state == DRAIN) begin
                if (!has_data) state <= RUN;
            end else begin
                word_count <= word_count + CNTWIDTH'(pop);
                count      <= count + 2'(push) - 2'(pop);
                if (push && (count == 2'd0 || (count == 2'd1 && pop))) b0 <= fifo_rdata;
                else if (pop && count == 2'd2) b0 <= b1;
                if (push && count == 2'd1 && !pop) b1 <= fifo_rdata;
            end
        end
    end
endmodule
